// File: rtl/bus_seg7_scanner.sv
// bus_seg7_scanner: bus-mapped, time-multiplexed multi-digit 7-segment
// display controller.
//
// The processor writes hex digits, a dot mask, a blank mask and a control
// byte over the shared 8-bit bus. The block scans NUM_DIGITS digits, one
// slot of SCAN_DIV clocks each. Digit data is copied into shadow registers
// once per scan frame, so a frame never shows a half-updated value.
//
// Register map (NB = NUM_DIGITS/2, offsets from BASE_ADDR, write-only):
//   k < NB : DATA_k  low nibble = digit 2k, high nibble = digit 2k+1
//   NB     : DOT     bit i lights the dp of digit i
//   NB+1   : BLANK   bit i forces digit i dark
//   NB+2   : CTRL    bit0 EN, bit1 LZS, bits7:4 BRIGHT, bits3:2 reserved
//
// Ports:
//   CLK           system clock
//   RESETN        asynchronous active-low reset
//   BUS_DATA      bus write data
//   BUS_ADDR      bus address
//   BUS_WE        bus write enable, one-cycle qualifier
//   DISP_SEL_OUT  digit select, active-low one-hot (bit i = digit i)
//   DISP_OUT      segments, active-low (bit0..6 = a..g, bit7 = dp)
//
// Optional feature macro: SEG7_PWM_EN
//   defined   : a free-running 4-bit counter dims lit digits; a lit digit
//               drives only while the counter <= BRIGHT.
//   undefined : BRIGHT is stored but has no effect.
module bus_seg7_scanner #(
  parameter logic [7:0]  BASE_ADDR  = 8'hD0,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 100000
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [7:0]            BUS_DATA,
  input  logic [7:0]            BUS_ADDR,
  input  logic                  BUS_WE,
  output logic [NUM_DIGITS-1:0] DISP_SEL_OUT,
  output logic [7:0]            DISP_OUT
);

  localparam int unsigned NB = NUM_DIGITS / 2;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PW = $clog2(SCAN_DIV);

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE   = PW'(SCAN_DIV - 1);
  localparam logic [7:0]    ADDR_DOT   = BASE_ADDR + 8'(NB);
  localparam logic [7:0]    ADDR_BLANK = BASE_ADDR + 8'(NB + 1);
  localparam logic [7:0]    ADDR_CTRL  = BASE_ADDR + 8'(NB + 2);

  // Bus-visible registers
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   dot_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [7:0]              ctrl_q;

  // Per-frame shadows
  logic [4*NUM_DIGITS-1:0] data_sh_q;
  logic [NUM_DIGITS-1:0]   dot_sh_q;
  logic [NUM_DIGITS-1:0]   blank_sh_q;

  // Scan state
  logic [PW-1:0] pre_q;
  logic [IW-1:0] idx_q;
  logic          tick;

  // Registered outputs
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;

  // Reserved CTRL bits (and BRIGHT when dimming is not built) are stored only.
  logic ctrl_unused;
  assign ctrl_unused = ^ctrl_q[7:2];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Register writes
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      data_q  <= '0;
      dot_q   <= '0;
      blank_q <= '0;
      ctrl_q  <= 8'hF1;
    end else if (BUS_WE) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (BUS_ADDR == BASE_ADDR + 8'(k)) data_q[8*k +: 8] <= BUS_DATA;
      end
      if (BUS_ADDR == ADDR_DOT)   dot_q   <= BUS_DATA[NUM_DIGITS-1:0];
      if (BUS_ADDR == ADDR_BLANK) blank_q <= BUS_DATA[NUM_DIGITS-1:0];
      if (BUS_ADDR == ADDR_CTRL)  ctrl_q  <= BUS_DATA;
    end
  end

  assign tick = (pre_q == LAST_PRE);

  // Prescaler, digit index and frame-boundary shadow capture. The shadow
  // copy samples the pre-edge register values, so a write landing on the
  // boundary edge only shows up in the following frame.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pre_q      <= '0;
      idx_q      <= '0;
      data_sh_q  <= '0;
      dot_sh_q   <= '0;
      blank_sh_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (idx_q == LAST_IDX) begin
          idx_q      <= '0;
          data_sh_q  <= data_q;
          dot_sh_q   <= dot_q;
          blank_sh_q <= blank_q;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

`ifdef SEG7_PWM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) pwm_q <= '0;
    else         pwm_q <= pwm_q + 4'd1;
  end
`endif

  // Output decode for the current digit
  logic [3:0] nibble;
  logic       dot_bit;
  logic       blank_bit;
  logic       nonzero_up;  // some shadow nibble at or above idx_q is nonzero
  logic       suppress;
  logic       lit;

  always_comb begin
    nibble     = '0;
    dot_bit    = 1'b0;
    blank_bit  = 1'b0;
    nonzero_up = 1'b0;
    sel_d      = '1;
    seg_d      = 8'hFF;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (IW'(j) == idx_q) begin
        nibble    = data_sh_q[4*j +: 4];
        dot_bit   = dot_sh_q[j];
        blank_bit = blank_sh_q[j];
      end
      if ((IW'(j) >= idx_q) && (data_sh_q[4*j +: 4] != 4'h0)) nonzero_up = 1'b1;
    end
    suppress = ctrl_q[1] && (idx_q != '0) && !nonzero_up;
    lit      = ctrl_q[0] && !blank_bit && !suppress;
`ifdef SEG7_PWM_EN
    lit      = lit && (pwm_q <= ctrl_q[7:4]);
`endif
    if (lit) begin
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
        if (IW'(j) == idx_q) sel_d[j] = 1'b0;
      end
      seg_d = {~dot_bit, hex7(nibble)};
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sel_q <= '1;
      seg_q <= 8'hFF;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign DISP_SEL_OUT = sel_q;
  assign DISP_OUT     = seg_q;

endmodule

// File: tb/tb_bus_seg7_scanner.sv
// Directed bench for bus_seg7_scanner with NUM_DIGITS=4, SCAN_DIV=4,
// BASE_ADDR=D0. Posedge n after reset release is cycle n; the digit shown
// at cycle n is ((n-1)/4)%4 and a new frame starts at cycles 16k+1.
module tb_bus_seg7_scanner;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic [7:0] BUS_DATA;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [3:0] DISP_SEL_OUT;
  logic [7:0] DISP_OUT;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  bus_seg7_scanner #(
    .BASE_ADDR (8'hD0),
    .NUM_DIGITS(4),
    .SCAN_DIV  (4)
  ) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .BUS_DATA    (BUS_DATA),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_WE      (BUS_WE),
    .DISP_SEL_OUT(DISP_SEL_OUT),
    .DISP_OUT    (DISP_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] es, input logic [7:0] eo);
    ncmp++;
    assert (DISP_SEL_OUT === es) else begin
      nfail++;
      $error("FAIL %s cyc=%0d sel got %h expected %h", tag, cyc, DISP_SEL_OUT, es);
    end
    ncmp++;
    assert (DISP_OUT === eo) else begin
      nfail++;
      $error("FAIL %s cyc=%0d seg got %h expected %h", tag, cyc, DISP_OUT, eo);
    end
  endtask

  // Step n cycles; o0..o3 are the expected segment bytes per digit
  // (FF means the digit is dark and no select line is driven).
  task automatic run(input string tag, input int n,
                     input logic [7:0] o0, input logic [7:0] o1,
                     input logic [7:0] o2, input logic [7:0] o3);
    logic [7:0] o [4];
    logic [7:0] eo;
    logic [3:0] es;
    int d;
    o[0] = o0; o[1] = o1; o[2] = o2; o[3] = o3;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      d  = ((cyc - 1) / 4) % 4;
      eo = o[d];
      es = 4'hF;
      if (eo != 8'hFF) es[d] = 1'b0;
      chk(tag, es, eo);
    end
  endtask

  task automatic wr(input string tag, input logic [7:0] addr, input logic [7:0] data,
                    input logic [7:0] o0, input logic [7:0] o1,
                    input logic [7:0] o2, input logic [7:0] o3);
    BUS_ADDR = addr;
    BUS_DATA = data;
    BUS_WE   = 1'b1;
    run(tag, 1, o0, o1, o2, o3);
    BUS_WE   = 1'b0;
    BUS_ADDR = 8'h00;
    BUS_DATA = 8'h00;
  endtask

  initial begin
    RESETN   = 1'b0;
    BUS_DATA = 8'h00;
    BUS_ADDR = 8'h00;
    BUS_WE   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("in_reset", 4'hF, 8'hFF);
    RESETN = 1'b1;
    cyc    = 0;

    // 1: idle scan, all digits show 0 with dp off
    run("idle", 16, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // 2: mid-frame writes do not disturb the current frame
    run("t2_pre", 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    wr("t2_wr0", 8'hD0, 8'h34, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    wr("t2_wr1", 8'hD1, 8'h12, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    wr("t2_dot", 8'hD2, 8'h04, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    run("t2_old", 12, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    run("t2_new", 16, 8'h99, 8'hB0, 8'h24, 8'hF9);

    // 3: leading-zero suppression, then EN=0
    wr("t3_wr1", 8'hD1, 8'h00, 8'h99, 8'hB0, 8'h24, 8'hF9);
    wr("t3_wr0", 8'hD0, 8'h05, 8'h99, 8'hB0, 8'h24, 8'hF9);
    wr("t3_lzs", 8'hD4, 8'hF3, 8'h99, 8'hB0, 8'h24, 8'hF9);
    run("t3_old", 13, 8'h99, 8'hB0, 8'h24, 8'hF9);
    run("t3_lz", 16, 8'h92, 8'hFF, 8'hFF, 8'hFF);
    run("t3_pre", 1, 8'h92, 8'hFF, 8'hFF, 8'hFF);
    wr("t3_off", 8'hD4, 8'hF0, 8'h92, 8'hFF, 8'hFF, 8'hFF);
    run("t3_dark", 14, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // 4: blank mask, re-enable, unmapped addresses ignored
    wr("t4_blk", 8'hD3, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wr("t4_wr0", 8'hD0, 8'hAB, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wr("t4_en", 8'hD4, 8'hF1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run("t4_on", 13, 8'h92, 8'hC0, 8'h40, 8'hC0);
    wr("t4_d5", 8'hD5, 8'h5A, 8'h83, 8'hFF, 8'h40, 8'hC0);
    wr("t4_cf", 8'hCF, 8'hFF, 8'h83, 8'hFF, 8'h40, 8'hC0);
    run("t4_blank", 14, 8'h83, 8'hFF, 8'h40, 8'hC0);
    run("t4_same", 15, 8'h83, 8'hFF, 8'h40, 8'hC0);

    // 5: write on the frame-boundary edge lands one frame late
    wr("t5_bnd", 8'hD0, 8'h77, 8'h83, 8'hFF, 8'h40, 8'hC0);
    run("t5_old", 16, 8'h83, 8'hFF, 8'h40, 8'hC0);
    run("t5_new", 16, 8'hF8, 8'hFF, 8'h40, 8'hC0);

    // 6: BRIGHT=3
    wr("t6_bri", 8'hD4, 8'h31, 8'hF8, 8'hFF, 8'h40, 8'hC0);
`ifdef SEG7_PWM_EN
    // pwm is (cycle-1)%16, so only the digit-0 slot falls in pwm 0..3
    run("t6_pwm", 31, 8'hF8, 8'hFF, 8'hFF, 8'hFF);
`else
    run("t6_full", 31, 8'hF8, 8'hFF, 8'h40, 8'hC0);
`endif

    // Mid-frame asynchronous reset, then restart from digit 0
    run("pre_rst", 6, 8'hF8, 8'hFF, 8'h40, 8'hC0);
    RESETN = 1'b0;
    #1;
    chk("async_rst", 4'hF, 8'hFF);
    repeat (2) @(posedge CLK);
    #1;
    chk("hold_rst", 4'hF, 8'hFF);
    RESETN = 1'b1;
    cyc    = 0;
    run("restart", 16, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
